// File: rtl/cache_tag_table_mp.sv
// L1 tag/state table with one CPU request port and NUM_SNP snoop channels.
// A post-reset sweep invalidates every entry before requests are accepted.
module cache_tag_table_mp #(
    parameter int NUM_ENTRY = 1024,
    parameter int INDEX_W   = 10,
    parameter int TAG_W     = 16,
    parameter int PA_W      = 32,
    parameter int OFFSET_W  = 2,
    parameter int NUM_SNP   = 2
) (
    input  logic                    clk,
    input  logic                    rst,
    output logic                    init_done,
    input  logic                    req_valid,
    output logic                    req_ready,
    input  logic [INDEX_W-1:0]      req_index,
    input  logic                    req_we_flag,
    input  logic [1:0]              req_new_flag,
    input  logic                    req_we_addr,
    input  logic [TAG_W-1:0]        req_new_tag,
    input  logic [PA_W-1:0]         req_new_pa,
    output logic                    rsp_valid,
    output logic                    rsp_hit,
    output logic [1:0]              rsp_flag,
    output logic [TAG_W-1:0]        rsp_tag,
    output logic [PA_W-1:0]         rsp_pa,
    input  logic [NUM_SNP-1:0]      snp_req,
    input  logic [NUM_SNP*PA_W-1:0] snp_addr,
    input  logic [NUM_SNP-1:0]      snp_inv,
    output logic [NUM_SNP-1:0]      snp_ack,
    output logic                    snp_match,
    output logic [1:0]              snp_flag,
    output logic [INDEX_W-1:0]      snp_index
);

    localparam int SW = (NUM_SNP > 1) ? $clog2(NUM_SNP) : 1;
    localparam logic [INDEX_W-1:0] LAST = INDEX_W'(NUM_ENTRY - 1);

    typedef enum logic {S_INIT, S_READY} state_e;

    state_e             state_q, state_d;
    logic [INDEX_W-1:0] ctr_q, ctr_d;
    logic               done_q, done_d;
    logic [SW-1:0]      last_q;

    logic [1:0]         flag_q [NUM_ENTRY];
    logic [TAG_W-1:0]   tag_q  [NUM_ENTRY];
    logic [PA_W-1:0]    pa_q   [NUM_ENTRY];

    logic               rsp_valid_q, rsp_hit_q;
    logic [1:0]         rsp_flag_q;
    logic [TAG_W-1:0]   rsp_tag_q;
    logic [PA_W-1:0]    rsp_pa_q;
    logic [NUM_SNP-1:0] snp_ack_q;
    logic               snp_match_q;
    logic [1:0]         snp_flag_q;
    logic [INDEX_W-1:0] snp_index_q;

    logic               gnt_vld;
    logic [SW-1:0]      gnt_c;
    logic [NUM_SNP-1:0] gnt_oh;
    logic [PA_W-1:0]    s_addr;
    logic [INDEX_W-1:0] s_idx;
    logic               s_inv, st_match, stall, req_acc;
    logic [1:0]         fw_flag, rsp_flag_d;
    logic [PA_W-1:0]    fw_pa;
    logic               s_match, s_kill;
    int                 c;

    always_comb begin
        state_d = state_q;
        ctr_d   = ctr_q;
        done_d  = done_q;
        if (state_q == S_INIT) begin
            ctr_d = ctr_q + INDEX_W'(1);
            if (ctr_q == LAST) begin
                state_d = S_READY;
                done_d  = 1'b1;
            end
        end
    end

    // A channel acked this cycle is still holding its request; skip it.
    always_comb begin
        gnt_vld = 1'b0;
        gnt_c   = '0;
        gnt_oh  = '0;
        c       = 0;
        if (state_q == S_READY) begin
            for (int i = 1; i <= NUM_SNP; i++) begin
                c = (int'(last_q) + i) % NUM_SNP;
                if (!gnt_vld && snp_req[c] && !snp_ack_q[c]) begin
                    gnt_vld = 1'b1;
                    gnt_c   = SW'(c);
                end
            end
        end
        if (gnt_vld) gnt_oh[gnt_c] = 1'b1;
    end

    always_comb begin
        s_addr   = snp_addr[int'(gnt_c)*PA_W +: PA_W];
        s_idx    = s_addr[OFFSET_W +: INDEX_W];
        s_inv    = snp_inv[gnt_c];
        st_match = (flag_q[s_idx] != 2'd0) && (pa_q[s_idx] == s_addr);
        stall    = gnt_vld && s_inv && st_match && (s_idx == req_index);
        req_ready = (state_q == S_READY) && !stall;
        req_acc  = req_valid && req_ready;
        fw_flag  = flag_q[s_idx];
        fw_pa    = pa_q[s_idx];
        if (req_acc && req_index == s_idx) begin
            if (req_we_flag) fw_flag = req_new_flag;
            if (req_we_addr) fw_pa = req_new_pa;
        end
        s_match  = (fw_flag != 2'd0) && (fw_pa == s_addr);
        s_kill   = gnt_vld && s_inv && s_match;
        rsp_flag_d = req_we_flag ? req_new_flag : flag_q[req_index];
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_INIT;
            ctr_q       <= '0;
            done_q      <= 1'b0;
            last_q      <= SW'(NUM_SNP - 1);
            rsp_valid_q <= 1'b0;
            rsp_hit_q   <= 1'b0;
            rsp_flag_q  <= '0;
            rsp_tag_q   <= '0;
            rsp_pa_q    <= '0;
            snp_ack_q   <= '0;
            snp_match_q <= 1'b0;
            snp_flag_q  <= '0;
            snp_index_q <= '0;
        end else begin
            state_q     <= state_d;
            ctr_q       <= ctr_d;
            done_q      <= done_d;
            rsp_valid_q <= req_acc;
            snp_ack_q   <= gnt_oh;
            if (gnt_vld) begin
                last_q      <= gnt_c;
                snp_match_q <= s_match;
                snp_flag_q  <= fw_flag;
                snp_index_q <= s_idx;
            end
            if (req_acc) begin
                rsp_flag_q <= rsp_flag_d;
                rsp_hit_q  <= rsp_flag_d != 2'd0;
                rsp_tag_q  <= req_we_addr ? req_new_tag : tag_q[req_index];
                rsp_pa_q   <= req_we_addr ? req_new_pa : pa_q[req_index];
            end
        end
    end

    // Snoop invalidate is written last so it wins over a CPU flag write.
    always_ff @(posedge clk) begin
        if (state_q == S_INIT) begin
            flag_q[ctr_q] <= '0;
            tag_q[ctr_q]  <= '0;
            pa_q[ctr_q]   <= '0;
        end else begin
            if (req_acc && req_we_flag) flag_q[req_index] <= req_new_flag;
            if (req_acc && req_we_addr) begin
                tag_q[req_index] <= req_new_tag;
                pa_q[req_index]  <= req_new_pa;
            end
            if (s_kill) flag_q[s_idx] <= 2'd0;
        end
    end

    assign init_done = done_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_hit   = rsp_hit_q;
    assign rsp_flag  = rsp_flag_q;
    assign rsp_tag   = rsp_tag_q;
    assign rsp_pa    = rsp_pa_q;
    assign snp_ack   = snp_ack_q;
    assign snp_match = snp_match_q;
    assign snp_flag  = snp_flag_q;
    assign snp_index = snp_index_q;

endmodule

// File: tb/tb_cache_tag_table_mp.sv
// Self-checking bench for cache_tag_table_mp: directed steps plus
// randomized CPU/snoop traffic against an array-based reference model.
module tb_cache_tag_table_mp;

    localparam int NE = 1024;
    localparam int IW = 10;
    localparam int TW = 16;
    localparam int PW = 32;
    localparam int NS = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          init_done;
    logic          req_valid, req_ready;
    logic [IW-1:0] req_index;
    logic          req_we_flag, req_we_addr;
    logic [1:0]    req_new_flag;
    logic [TW-1:0] req_new_tag;
    logic [PW-1:0] req_new_pa;
    logic          rsp_valid, rsp_hit;
    logic [1:0]    rsp_flag;
    logic [TW-1:0] rsp_tag;
    logic [PW-1:0] rsp_pa;
    logic [NS-1:0] snp_req, snp_inv, snp_ack;
    logic [NS*PW-1:0] snp_addr;
    logic          snp_match;
    logic [1:0]    snp_flag;
    logic [IW-1:0] snp_index;

    cache_tag_table_mp dut (
        .clk(clk), .rst(rst), .init_done(init_done),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_index(req_index), .req_we_flag(req_we_flag),
        .req_new_flag(req_new_flag), .req_we_addr(req_we_addr),
        .req_new_tag(req_new_tag), .req_new_pa(req_new_pa),
        .rsp_valid(rsp_valid), .rsp_hit(rsp_hit), .rsp_flag(rsp_flag),
        .rsp_tag(rsp_tag), .rsp_pa(rsp_pa),
        .snp_req(snp_req), .snp_addr(snp_addr), .snp_inv(snp_inv),
        .snp_ack(snp_ack), .snp_match(snp_match),
        .snp_flag(snp_flag), .snp_index(snp_index)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic [1:0]    m_flag [NE];
    logic [TW-1:0] m_tag  [NE];
    logic [PW-1:0] m_pa   [NE];
    int            pool   [8] = '{0, 1, 2, 3, 5, 511, 512, 1023};

    task automatic chk(input string tag, input logic [63:0] obs,
                       input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        req_valid   = 1'b0;
        req_we_flag = 1'b0;
        req_we_addr = 1'b0;
        snp_req     = '0;
        snp_inv     = '0;
    endtask

    task automatic model_clear();
        for (int i = 0; i < NE; i++) begin
            m_flag[i] = '0;
            m_tag[i]  = '0;
            m_pa[i]   = '0;
        end
    endtask

    task automatic sweep(input string tag);
        int n;
        n = 0;
        for (int i = 1; i <= 2000; i++) begin
            cyc();
            if (init_done === 1'b1) begin
                n = i;
                break;
            end
        end
        chk(tag, n, NE);
        model_clear();
    endtask

    task automatic cpu(input int idx, input bit wf, input logic [1:0] f,
                       input bit wa, input logic [TW-1:0] t,
                       input logic [PW-1:0] p);
        req_valid    = 1'b1;
        req_index    = idx[IW-1:0];
        req_we_flag  = wf;
        req_new_flag = f;
        req_we_addr  = wa;
        req_new_tag  = t;
        req_new_pa   = p;
        #1;
        chk("req_ready", req_ready, 1);
        cyc();
        req_valid   = 1'b0;
        req_we_flag = 1'b0;
        req_we_addr = 1'b0;
        if (wf) m_flag[idx] = f;
        if (wa) begin
            m_tag[idx] = t;
            m_pa[idx]  = p;
        end
        chk("rsp_valid", rsp_valid, 1);
        chk("rsp_flag", rsp_flag, m_flag[idx]);
        chk("rsp_tag", rsp_tag, m_tag[idx]);
        chk("rsp_pa", rsp_pa, m_pa[idx]);
        chk("rsp_hit", rsp_hit, m_flag[idx] != 2'd0);
    endtask

    task automatic snoop(input int ch, input logic [PW-1:0] a, input bit inv);
        int            idx;
        bit            got;
        logic          m;
        logic [NS-1:0] ea;
        snp_addr[ch*PW +: PW] = a;
        snp_inv[ch] = inv;
        snp_req[ch] = 1'b1;
        got = 1'b0;
        for (int i = 0; i < 6; i++) begin
            cyc();
            if (snp_ack !== '0) begin
                got = 1'b1;
                break;
            end
        end
        snp_req[ch] = 1'b0;
        snp_inv[ch] = 1'b0;
        chk("snp_ack_seen", got, 1);
        idx = int'(a >> 2) % NE;
        m = (m_flag[idx] != 2'd0) && (m_pa[idx] == a);
        ea = '0;
        ea[ch] = 1'b1;
        chk("snp_ack", snp_ack, ea);
        chk("snp_match", snp_match, m);
        chk("snp_flag", snp_flag, m_flag[idx]);
        chk("snp_index", snp_index, idx);
        if (inv && m) m_flag[idx] = 2'd0;
    endtask

    function automatic logic [PW-1:0] mk_pa(input int idx);
        logic [PW-1:0] hi;
        hi = PW'($urandom_range(0, 3)) << 12;
        return hi | (PW'(idx) << 2) | PW'($urandom_range(0, 3));
    endfunction

    initial begin
        idle();
        req_index    = '0;
        req_new_flag = '0;
        req_new_tag  = '0;
        req_new_pa   = '0;
        snp_addr     = '0;
        model_clear();

        repeat (3) cyc();
        chk("rst_init_done", init_done, 0);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_rsp_valid", rsp_valid, 0);
        chk("rst_snp_ack", snp_ack, 0);
        rst = 1'b1;
        sweep("init_sweep_len");

        cpu(5, 0, 2'd0, 0, '0, '0);
        cyc();
        chk("rsp_valid_1cyc", rsp_valid, 0);

        cpu(3, 1, 2'd3, 1, 16'hABCD, 32'h0000_100C);
        cpu(3, 0, 2'd0, 0, '0, '0);

        snoop(0, 32'h0000_100C, 0);
        snoop(0, 32'h0000_200C, 0);
        cyc();

        snp_addr[PW +: PW] = 32'h0000_100C;
        snp_inv     = 2'b10;
        snp_req     = 2'b10;
        req_valid   = 1'b1;
        req_index   = 10'd3;
        req_we_flag = 1'b0;
        req_we_addr = 1'b1;
        req_new_tag = 16'h1111;
        req_new_pa  = 32'h0000_100C;
        #1;
        chk("conf_ready_stall", req_ready, 0);
        cyc();
        chk("conf_ack", snp_ack, 2'b10);
        chk("conf_match", snp_match, 1);
        chk("conf_flag_before", snp_flag, 3);
        chk("conf_no_rsp", rsp_valid, 0);
        snp_req = '0;
        snp_inv = '0;
        #1;
        chk("conf_ready_retry", req_ready, 1);
        cyc();
        idle();
        m_flag[3] = 2'd0;
        m_tag[3]  = 16'h1111;
        m_pa[3]   = 32'h0000_100C;
        chk("conf_rsp_valid", rsp_valid, 1);
        chk("conf_rsp_flag", rsp_flag, m_flag[3]);
        chk("conf_rsp_tag", rsp_tag, m_tag[3]);
        chk("conf_rsp_hit", rsp_hit, 0);
        cyc();

        for (int n = 0; n < 300; n++) begin
            int idx;
            idx = pool[$urandom_range(0, 7)];
            if ($urandom_range(0, 1) == 0) begin
                cpu(idx, 1'($urandom), 2'($urandom), 1'($urandom),
                    TW'($urandom), mk_pa(idx));
            end else begin
                logic [PW-1:0] a;
                a = ($urandom_range(0, 1) == 0) ? m_pa[idx] : mk_pa(idx);
                snoop($urandom_range(0, NS - 1), a, 1'($urandom));
            end
        end

        idle();
        cyc();
        rst = 1'b0;
        #1;
        chk("rst2_init_done", init_done, 0);
        chk("rst2_rsp_flag", rsp_flag, 0);
        chk("rst2_snp_index", snp_index, 0);
        cyc();
        rst = 1'b1;
        repeat (500) cyc();
        rst = 1'b0;
        #1;
        chk("mid_init_done", init_done, 0);
        chk("mid_rsp_valid", rsp_valid, 0);
        chk("mid_snp_ack", snp_ack, 0);
        chk("mid_snp_match", snp_match, 0);
        chk("mid_snp_flag", snp_flag, 0);
        cyc();
        rst = 1'b1;
        sweep("resweep_len");

        snp_addr = {32'h0000_100C, 32'h0000_100C};
        snp_req  = 2'b11;
        for (int k = 0; k < 4; k++) begin
            cyc();
            chk("rr_ack", snp_ack, (k % 2 == 0) ? 2'b01 : 2'b10);
            chk("rr_match", snp_match, 0);
        end
        idle();
        cyc();
        chk("rr_idle_ack", snp_ack, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
